// File: rtl/mario_sprite_pixel_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mario_sprite_pixel_if
//  Purpose  : Bundles the scan-position, sync, sprite-control, ROM and
//             palette-index signals of the sprite pixel stage.
//             master = video timing / game logic / ROM side,
//             slave  = the sprite pixel stage itself.
//  Revision : 1.0  initial release
// ============================================================================
interface mario_sprite_pixel_if #(
  parameter int unsigned W_BITS     = 4,
  parameter int unsigned H_BITS     = 5,
  parameter int unsigned FRAME_BITS = 2
);
  localparam int unsigned ADDR_W = FRAME_BITS + H_BITS + W_BITS;

  // scan position and timing
  logic [9:0]            DrawX;
  logic [9:0]            DrawY;
  logic                  de;
  logic                  hs;
  logic                  vs;
  // sprite placement from game logic
  logic [9:0]            sprite_x;
  logic [9:0]            sprite_y;
  logic [FRAME_BITS-1:0] frame_sel;
  logic                  flip_x;
  // sprite ROM (synchronous, one-cycle read)
  logic [ADDR_W-1:0]     rom_addr;
  logic [7:0]            rom_data;
  // results aligned with each other
  logic [7:0]            index;
  logic                  opaque;
  logic                  hs_o;
  logic                  vs_o;
  logic                  de_o;

  modport master (
    output DrawX, DrawY, de, hs, vs,
    output sprite_x, sprite_y, frame_sel, flip_x,
    output rom_data,
    input  rom_addr,
    input  index, opaque, hs_o, vs_o, de_o
  );

  modport slave (
    input  DrawX, DrawY, de, hs, vs,
    input  sprite_x, sprite_y, frame_sel, flip_x,
    input  rom_data,
    output rom_addr,
    output index, opaque, hs_o, vs_o, de_o
  );
endinterface
`default_nettype wire

// File: rtl/mario_sprite_pixel.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mario_sprite_pixel
//  Purpose  : Per-pixel sprite stage in front of the palette lookup. Maps the
//             scan position to a sprite ROM address, reads the 8-bit palette
//             index, substitutes the background index for transparent or
//             uncovered pixels and delays hs/vs/de to stay aligned.
//             Latency 3 clocks, one pixel per clock.
//  Options  : define MARIO_SPRITE_FLIP_EN to build horizontal mirroring
//             driven by flip_x; otherwise flip_x is ignored.
//  Revision : 1.0  initial release
// ============================================================================
module mario_sprite_pixel #(
  parameter int unsigned W_BITS          = 4,
  parameter int unsigned H_BITS          = 5,
  parameter int unsigned FRAME_BITS      = 2,
  parameter int unsigned SCALE_SHIFT     = 1,
  parameter logic [7:0]  TRANSPARENT_IDX = 8'd0,
  parameter logic [7:0]  BG_IDX          = 8'd4
) (
  input  wire logic           Clk,
  input  wire logic           Reset_n,
  mario_sprite_pixel_if.slave bus
);

  localparam int unsigned c_ADDR_W = FRAME_BITS + H_BITS + W_BITS;
  // On-screen sprite box size in pixels (texels scaled up)
  localparam logic [10:0] c_BOX_W = 11'((1 << W_BITS) << SCALE_SHIFT);
  localparam logic [10:0] c_BOX_H = 11'((1 << H_BITS) << SCALE_SHIFT);

  // --------------------------------------------------------------------------
  // Shadow copies of the sprite controls, refreshed once per frame
  // --------------------------------------------------------------------------
  logic                  r_vs_prev;
  logic [9:0]            r_sx;
  logic [9:0]            r_sy;
  logic [FRAME_BITS-1:0] r_frame;
  logic                  w_capture;

  // vsync rising edge: the frame has just ended, safe to move the sprite
  assign w_capture = bus.vs & ~r_vs_prev;

  // Capture position/frame on the vsync rising edge so a frame never tears
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_vs_prev <= 1'b1;
      r_sx      <= '0;
      r_sy      <= '0;
      r_frame   <= '0;
    end else begin
      r_vs_prev <= bus.vs;
      if (w_capture) begin
        r_sx    <= bus.sprite_x;
        r_sy    <= bus.sprite_y;
        r_frame <= bus.frame_sel;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 1 address generation
  // --------------------------------------------------------------------------
  logic [10:0]       w_dx;
  logic [10:0]       w_dy;
  logic              w_hit1;
  logic [W_BITS-1:0] w_lx_raw;
  logic [W_BITS-1:0] w_lx;
  logic [H_BITS-1:0] w_ly;

  // 11-bit subtraction: a scan position left of / above the sprite wraps to a
  // value >= 1024, so a single unsigned compare rejects both sides of the box
  assign w_dx     = {1'b0, bus.DrawX} - {1'b0, r_sx};
  assign w_dy     = {1'b0, bus.DrawY} - {1'b0, r_sy};
  assign w_hit1   = bus.de & (w_dx < c_BOX_W) & (w_dy < c_BOX_H);
  assign w_lx_raw = w_dx[SCALE_SHIFT +: W_BITS];
  assign w_ly     = w_dy[SCALE_SHIFT +: H_BITS];

`ifdef MARIO_SPRITE_FLIP_EN
  logic r_flip;

  // Mirror flag follows the same once-per-frame capture as the position
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_flip <= 1'b0;
    end else if (w_capture) begin
      r_flip <= bus.flip_x;
    end
  end

  // XOR with all ones gives (2**W_BITS-1)-lx, i.e. a mirrored column
  assign w_lx = w_lx_raw ^ {W_BITS{r_flip}};
`else
  logic w_unused_flip;

  assign w_unused_flip = bus.flip_x;
  assign w_lx          = w_lx_raw;
`endif

  logic [c_ADDR_W-1:0] r_rom_addr;
  logic                r_hit1;
  logic                r_hs1;
  logic                r_vs1;
  logic                r_de1;

  // Register ROM address (held outside the box) and pipe hit/syncs
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_rom_addr <= '0;
      r_hit1     <= 1'b0;
      r_hs1      <= 1'b1;
      r_vs1      <= 1'b1;
      r_de1      <= 1'b0;
    end else begin
      if (w_hit1) begin
        r_rom_addr <= {r_frame, w_ly, w_lx};
      end
      r_hit1 <= w_hit1;
      r_hs1  <= bus.hs;
      r_vs1  <= bus.vs;
      r_de1  <= bus.de;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: the ROM performs its read; carry the side information along
  // --------------------------------------------------------------------------
  logic r_hit2;
  logic r_hs2;
  logic r_vs2;
  logic r_de2;

  // Delay hit and syncs by one clock to meet the ROM read data
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_hit2 <= 1'b0;
      r_hs2  <= 1'b1;
      r_vs2  <= 1'b1;
      r_de2  <= 1'b0;
    end else begin
      r_hit2 <= r_hit1;
      r_hs2  <= r_hs1;
      r_vs2  <= r_vs1;
      r_de2  <= r_de1;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 3: transparency test and registered outputs
  // --------------------------------------------------------------------------
  logic       w_opaque;
  logic [7:0] r_index;
  logic       r_opaque;
  logic       r_hs3;
  logic       r_vs3;
  logic       r_de3;

  assign w_opaque = r_hit2 & (bus.rom_data != TRANSPARENT_IDX);

  // Choose sprite texel or background index and align the syncs with it
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_index  <= BG_IDX;
      r_opaque <= 1'b0;
      r_hs3    <= 1'b1;
      r_vs3    <= 1'b1;
      r_de3    <= 1'b0;
    end else begin
      r_index  <= w_opaque ? bus.rom_data : BG_IDX;
      r_opaque <= w_opaque;
      r_hs3    <= r_hs2;
      r_vs3    <= r_vs2;
      r_de3    <= r_de2;
    end
  end

  assign bus.rom_addr = r_rom_addr;
  assign bus.index    = r_index;
  assign bus.opaque   = r_opaque;
  assign bus.hs_o     = r_hs3;
  assign bus.vs_o     = r_vs3;
  assign bus.de_o     = r_de3;

endmodule
`default_nettype wire

// File: tb/tb_mario_sprite_pixel.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_mario_sprite_pixel
//  Purpose  : Directed self-checking bench for mario_sprite_pixel with a
//             synchronous sprite ROM model and a small pixel reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mario_sprite_pixel;

`ifdef MARIO_SPRITE_FLIP_EN
  localparam bit FLIP_ON = 1'b1;
`else
  localparam bit FLIP_ON = 1'b0;
`endif

  typedef struct {
    logic [7:0] idx;
    logic       op;
    logic       hs;
    logic       vs;
    logic       de;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic hs_v;
  logic vs_v;
  int   ref_sx;
  int   ref_sy;
  int   ref_fr;
  bit   ref_fl;
  bit   ref_prev_vs;
  exp_t q[$];
  logic [7:0] rom_mem [0:2047];

  mario_sprite_pixel_if ifc ();

  mario_sprite_pixel dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous one-cycle ROM
  always @(posedge clk) ifc.rom_data <= rom_mem[ifc.rom_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push_reset_entries();
    exp_t e;
    e.idx = 8'h04; e.op = 1'b0; e.hs = 1'b1; e.vs = 1'b1; e.de = 1'b0;
    q.push_back(e);
    q.push_back(e);
  endtask

  // drive one pixel, predict its outputs, advance a clock, check pixel k-2
  task automatic pix(input int x, input int y, input bit de);
    exp_t       e;
    int         dx;
    int         dy;
    int         col;
    bit         hit;
    logic [7:0] t;
    ifc.DrawX = 10'(x);
    ifc.DrawY = 10'(y);
    ifc.de    = de;
    ifc.hs    = hs_v;
    ifc.vs    = vs_v;
    dx  = x - ref_sx;
    dy  = y - ref_sy;
    hit = de && dx >= 0 && dx < 32 && dy >= 0 && dy < 64;
    t   = 8'h00;
    if (hit) begin
      col = dx / 2;
      if (FLIP_ON && ref_fl) col = 15 - col;
      t = rom_mem[11'(ref_fr * 512 + (dy / 2) * 16 + col)];
    end
    e.op  = hit && (t != 8'h00);
    e.idx = e.op ? t : 8'h04;
    e.hs  = hs_v;
    e.vs  = vs_v;
    e.de  = de;
    q.push_back(e);
    if (vs_v && !ref_prev_vs) begin
      ref_sx = int'(ifc.sprite_x);
      ref_sy = int'(ifc.sprite_y);
      ref_fr = int'(ifc.frame_sel);
      ref_fl = ifc.flip_x;
    end
    ref_prev_vs = vs_v;
    tick();
    if (q.size() >= 3) begin
      e = q.pop_front();
      chk("index", 16'(ifc.index), 16'(e.idx));
      chk("opaque", 16'(ifc.opaque), 16'(e.op));
      chk("hs_o", 16'(ifc.hs_o), 16'(e.hs));
      chk("vs_o", 16'(ifc.vs_o), 16'(e.vs));
      chk("de_o", 16'(ifc.de_o), 16'(e.de));
    end
  endtask

  task automatic vsync();
    vs_v = 1'b0;
    for (int i = 0; i < 3; i++) pix(700, 490, 1'b0);
    vs_v = 1'b1;
    pix(700, 490, 1'b0);
  endtask

  // isolated pixel with hand-computed address and result
  task automatic probe(input int x, input int y, input bit de, input bit do_addr,
                       input int exp_addr, input logic [7:0] exp_idx, input bit exp_op);
    pix(x, y, de);
    if (do_addr) chk("probe_addr", 16'(ifc.rom_addr), 16'(exp_addr));
    pix(640, 0, 1'b0);
    pix(640, 0, 1'b0);
    chk("probe_index", 16'(ifc.index), 16'(exp_idx));
    chk("probe_opaque", 16'(ifc.opaque), 16'(exp_op));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int a = 0; a < 2048; a++) rom_mem[a] = {2'b01, 6'(a)};
    rom_mem[3] = 8'h00;
    rom_mem[5] = 8'h17;

    // ---------------- power-on reset ----------------
    rst_n         = 1'b0;
    hs_v          = 1'b1;
    vs_v          = 1'b0;
    ifc.DrawX     = '0;
    ifc.DrawY     = '0;
    ifc.de        = 1'b1;
    ifc.hs        = 1'b0;
    ifc.vs        = 1'b0;
    ifc.sprite_x  = 10'd100;
    ifc.sprite_y  = 10'd50;
    ifc.frame_sel = 2'd0;
    ifc.flip_x    = 1'b0;
    tick(); tick(); tick();
    chk("rst_index", 16'(ifc.index), 16'h04);
    chk("rst_opaque", 16'(ifc.opaque), 16'h0);
    chk("rst_hs_o", 16'(ifc.hs_o), 16'h1);
    chk("rst_vs_o", 16'(ifc.vs_o), 16'h1);
    chk("rst_de_o", 16'(ifc.de_o), 16'h0);
    chk("rst_addr", 16'(ifc.rom_addr), 16'h0);
    #2 rst_n = 1'b1;
    ref_sx = 0; ref_sy = 0; ref_fr = 0; ref_fl = 1'b0; ref_prev_vs = 1'b0;
    push_reset_entries();

    // ---------------- sprite at (100,50), one scan line ----------------
    vsync();
    for (int x = 98; x <= 133; x++) begin
      pix(x, 50, 1'b1);
      if (x >= 100 && x <= 131) chk("lx_seq", 16'(ifc.rom_addr), 16'((x - 100) >> 1));
      if (x == 132) chk("addr_hold", 16'(ifc.rom_addr), 16'd15);
    end
    probe(132, 50, 1'b1, 1'b0, 0, 8'h04, 1'b0);
    probe(99, 50, 1'b1, 1'b0, 0, 8'h04, 1'b0);

    // ---------------- transparency and box edges ----------------
    probe(106, 50, 1'b1, 1'b1, 3, 8'h04, 1'b0);
    probe(110, 50, 1'b1, 1'b1, 5, 8'h17, 1'b1);
    probe(100, 50, 1'b1, 1'b1, 0, 8'h40, 1'b1);
    probe(100, 50, 1'b0, 1'b0, 0, 8'h04, 1'b0);
    probe(101, 52, 1'b1, 1'b1, 16, 8'h50, 1'b1);
    probe(100, 113, 1'b1, 1'b1, 496, 8'h70, 1'b1);
    probe(100, 114, 1'b1, 1'b0, 0, 8'h04, 1'b0);
    hs_v = 1'b0;
    probe(102, 50, 1'b1, 1'b1, 1, 8'h41, 1'b1);
    hs_v = 1'b1;

    // ---------------- animation frame ----------------
    ifc.frame_sel = 2'd2;
    vsync();
    probe(102, 50, 1'b1, 1'b1, 1025, 8'h41, 1'b1);
    ifc.frame_sel = 2'd0;
    vsync();

    // ---------------- shadow registers ----------------
    ifc.sprite_x = 10'd200;
    probe(100, 50, 1'b1, 1'b1, 0, 8'h40, 1'b1);
    probe(200, 50, 1'b1, 1'b0, 0, 8'h04, 1'b0);
    vsync();
    probe(200, 50, 1'b1, 1'b1, 0, 8'h40, 1'b1);
    probe(100, 50, 1'b1, 1'b0, 0, 8'h04, 1'b0);
    // change on the capture clock: pixel in flight still uses 200
    vs_v = 1'b0;
    pix(700, 490, 1'b0);
    pix(700, 490, 1'b0);
    ifc.sprite_x = 10'd300;
    vs_v = 1'b1;
    pix(200, 50, 1'b1);
    pix(640, 0, 1'b0);
    pix(640, 0, 1'b0);
    chk("capture_inflight_index", 16'(ifc.index), 16'h40);
    probe(300, 50, 1'b1, 1'b1, 0, 8'h40, 1'b1);

    // ---------------- right screen edge, no wrap ----------------
    ifc.sprite_x = 10'd630;
    vsync();
    for (int x = 620; x <= 639; x++) pix(x, 50, 1'b1);
    for (int x = 0; x <= 15; x++) pix(x, 50, 1'b1);
    probe(630, 50, 1'b1, 1'b1, 0, 8'h40, 1'b1);
    probe(639, 50, 1'b1, 1'b1, 4, 8'h44, 1'b1);
    probe(5, 50, 1'b1, 1'b0, 0, 8'h04, 1'b0);
    ifc.sprite_x = 10'd700;
    vsync();
    for (int x = 0; x <= 639; x++) pix(x, 50, 1'b1);
    probe(639, 50, 1'b1, 1'b0, 0, 8'h04, 1'b0);

    // ---------------- horizontal flip ----------------
    ifc.sprite_x = 10'd100;
    ifc.flip_x   = 1'b1;
    vsync();
    probe(100, 50, 1'b1, 1'b1, FLIP_ON ? 15 : 0, FLIP_ON ? 8'h4F : 8'h40, 1'b1);
    probe(131, 50, 1'b1, 1'b1, FLIP_ON ? 0 : 15, FLIP_ON ? 8'h40 : 8'h4F, 1'b1);
    ifc.flip_x = 1'b0;
    vsync();

    // ---------------- asynchronous reset mid-line ----------------
    for (int x = 100; x <= 105; x++) pix(x, 50, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_index", 16'(ifc.index), 16'h04);
    chk("mid_rst_opaque", 16'(ifc.opaque), 16'h0);
    chk("mid_rst_hs_o", 16'(ifc.hs_o), 16'h1);
    chk("mid_rst_vs_o", 16'(ifc.vs_o), 16'h1);
    chk("mid_rst_de_o", 16'(ifc.de_o), 16'h0);
    chk("mid_rst_addr", 16'(ifc.rom_addr), 16'h0);
    q.delete();
    vs_v = 1'b0;
    hs_v = 1'b0;
    ifc.vs = 1'b0;
    ifc.hs = 1'b0;
    #2 rst_n = 1'b1;
    ref_sx = 0; ref_sy = 0; ref_fr = 0; ref_fl = 1'b0; ref_prev_vs = 1'b0;
    push_reset_entries();
    // shadows cleared: sprite now sits at the origin until the next vsync
    probe(5, 5, 1'b1, 1'b1, 34, 8'h62, 1'b1);
    hs_v = 1'b1;
    vsync();
    probe(100, 50, 1'b1, 1'b1, 0, 8'h40, 1'b1);
    probe(5, 5, 1'b1, 1'b0, 0, 8'h04, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
